// File: rtl/reg_xfer_ctrl_pkg.sv
// srp16_regctl_pkg: shared op encodings, sequencer states and bank geometry defaults
package srp16_regctl_pkg;
  localparam int NREGS_DEF = 16;
  localparam int DW_DEF = 16;
  typedef enum logic [1:0] {OP_MOV = 2'd0, OP_LDI = 2'd1, OP_LDU = 2'd2, OP_XCHG = 2'd3} op_e;
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, DONE} state_e;
endpackage

// File: rtl/reg_xfer_ctrl_idx_onehot.sv
// idx_onehot: register index to one-hot select, all-zero when disabled or out of range
module idx_onehot #(
  parameter int NREGS = 16,
  parameter int IDX_W = 4
) (
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  output logic [NREGS-1:0] oh
);
  always_comb begin
    oh = '0;
    for (int i = 0; i < NREGS; i++) oh[i] = en && (int'(idx) == i);
  end
endmodule

// File: rtl/reg_xfer_ctrl.sv
// reg_xfer_ctrl: sequences MOV/LDI/LDU/XCHG transfers as one-hot strobes into the register bank
module reg_xfer_ctrl import srp16_regctl_pkg::*; #(
  parameter int NREGS = NREGS_DEF,
  parameter int DW    = DW_DEF,
  parameter int IDX_W = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_dst,
  input  logic [IDX_W-1:0] req_src,
  input  logic [DW-1:0]    req_imm,
  input  logic [DW-1:0]    bus_in,
  output logic [DW-1:0]    bus_out,
  output logic [NREGS-1:0] reg_read,
  output logic [NREGS-1:0] reg_write,
  output logic [NREGS-1:0] reg_writeu,
  output logic             done
);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [IDX_W-1:0] dst_q, dst_d, src_q, src_d, idx;
  logic [DW-1:0] imm_q, imm_d, tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d, wdata;
  logic accept, rd, wr;
  logic [NREGS-1:0] sel;
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept = req_valid && req_ready;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = accept ? (op_e'(req_op) inside {OP_LDI, OP_LDU} ? WR_A : RD_A) : IDLE;
      RD_A: state_d = (op_q == OP_XCHG) ? RD_B : WR_A;
      RD_B: state_d = WR_A;
      WR_A: state_d = (op_q == OP_XCHG) ? WR_B : DONE;
      WR_B: state_d = DONE;
      default: state_d = IDLE;
    endcase
    op_d = accept ? op_e'(req_op) : op_q;
    dst_d = accept ? req_dst : dst_q;
    src_d = accept ? req_src : src_q;
    imm_d = accept ? req_imm : imm_q;
    tmp_a_d = (state_q == RD_A) ? bus_in : tmp_a_q;
    tmp_b_d = (state_q == RD_B) ? bus_in : tmp_b_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= OP_MOV;
      dst_q <= '0;
      src_q <= '0;
      imm_q <= '0;
      tmp_a_q <= '0;
      tmp_b_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      dst_q <= dst_d;
      src_q <= src_d;
      imm_q <= imm_d;
      tmp_a_q <= tmp_a_d;
      tmp_b_q <= tmp_b_d;
    end
  end
  // Source is touched first on read and last on write; everything else targets dst.
  assign rd = state_q inside {RD_A, RD_B};
  assign wr = state_q inside {WR_A, WR_B};
  assign idx = (state_q == RD_A || state_q == WR_B) ? src_q : dst_q;
  idx_onehot #(.NREGS(NREGS), .IDX_W(IDX_W)) u_sel (
    .en (rd || wr),
    .idx(idx),
    .oh (sel)
  );
  assign wdata = (state_q == WR_B) ? tmp_b_q :
                 (op_q == OP_LDI)  ? imm_q :
                 (op_q == OP_LDU)  ? {{(DW-8){1'b0}}, imm_q[7:0]} : tmp_a_q;
  assign reg_read = rd ? sel : '0;
  assign reg_write = (wr && op_q != OP_LDU) ? sel : '0;
  assign reg_writeu = (wr && op_q == OP_LDU) ? sel : '0;
  assign bus_out = |(reg_write | reg_writeu) ? wdata : '0;
  assign done = (state_q == DONE);
endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// tb_reg_xfer_ctrl: drives reg_xfer_ctrl against a behavioural 16-register bank and an op-level reference
module tb_reg_xfer_ctrl;
  logic clk = 0, rst = 1, req_valid = 0, done;
  logic req_ready;
  logic [1:0] req_op = 0;
  logic [3:0] req_dst = 0, req_src = 0;
  logic [15:0] req_imm = 0, bus_in, bus_out;
  logic [15:0] reg_read, reg_write, reg_writeu;
  logic [15:0] bank [16] = '{default: 16'h0};
  logic [15:0] ref_m [16] = '{default: 16'h0};
  logic [15:0] rec_rd [32], rec_wr [32];
  logic [15:0] fw_wr, fw_wu, fw_bus;
  int pass_cnt = 0, total_cnt = 0, done_cnt = 0;
  int lat_tab [4] = '{3, 2, 2, 5};
  typedef struct {
    logic [1:0] op; logic [3:0] dst, src; logic [15:0] imm;
    logic [15:0] wr, wu, bus; logic [3:0] chk; logic [15:0] val; int lat;
  } vec_t;
  vec_t tab [7];

  reg_xfer_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_dst(req_dst), .req_src(req_src), .req_imm(req_imm),
    .bus_in(bus_in), .bus_out(bus_out), .reg_read(reg_read), .reg_write(reg_write),
    .reg_writeu(reg_writeu), .done(done)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus_in = '0;
    for (int i = 0; i < 16; i++) if (reg_read[i]) bus_in |= bank[i];
  end

  always @(posedge clk)
    for (int i = 0; i < 16; i++)
      if (reg_write[i]) bank[i] <= bus_out;
      else if (reg_writeu[i]) bank[i][15:8] <= bus_out[7:0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst) begin
      chk("strobe_onehot0", {31'd0, $onehot0({reg_read, reg_write, reg_writeu})}, 1);
      if ((reg_write | reg_writeu) == 0) chk("bus_idle_zero", {16'd0, bus_out}, 0);
    end
  end

  function automatic void apply_ref(input logic [1:0] op, input logic [3:0] d, s, input logic [15:0] imm);
    logic [15:0] t;
    case (op)
      2'd0: ref_m[d] = ref_m[s];
      2'd1: ref_m[d] = imm;
      2'd2: ref_m[d][15:8] = imm[7:0];
      default: begin t = ref_m[d]; ref_m[d] = ref_m[s]; ref_m[s] = t; end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [3:0] d, s, input logic [15:0] imm, output int lat);
    int w;
    @(negedge clk);
    req_valid = 1; req_op = op; req_dst = d; req_src = s; req_imm = imm;
    w = 0;
    while (!req_ready && w < 20) begin @(negedge clk); w++; end
    if (w == 20) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 0; req_op = 2'($urandom); req_dst = 4'($urandom); req_src = 4'($urandom); req_imm = 16'($urandom);
    lat = 0; fw_wr = 0; fw_wu = 0; fw_bus = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lat++;
      rec_rd[c] = reg_read; rec_wr[c] = reg_write;
      if ((fw_wr | fw_wu) == 0 && (reg_write | reg_writeu) != 0) begin
        fw_wr = reg_write; fw_wu = reg_writeu; fw_bus = bus_out;
      end
      if (done) break;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int lat, n, t0, t1, mism, dc;
    logic found;
    logic [1:0] op;
    logic [3:0] d, s;
    logic [15:0] imm;
    tab[0] = '{2'd1, 4'd3, 4'd0, 16'h0F0F, 16'h0008, 16'h0000, 16'h0F0F, 4'd3, 16'h0F0F, 2};
    tab[1] = '{2'd2, 4'd3, 4'd0, 16'h0003, 16'h0000, 16'h0008, 16'h0003, 4'd3, 16'h030F, 2};
    tab[2] = '{2'd1, 4'd1, 4'd0, 16'h1234, 16'h0002, 16'h0000, 16'h1234, 4'd1, 16'h1234, 2};
    tab[3] = '{2'd1, 4'd2, 4'd0, 16'hABCD, 16'h0004, 16'h0000, 16'hABCD, 4'd2, 16'hABCD, 2};
    tab[4] = '{2'd3, 4'd1, 4'd2, 16'h5555, 16'h0002, 16'h0000, 16'hABCD, 4'd1, 16'hABCD, 5};
    tab[5] = '{2'd1, 4'd5, 4'd0, 16'h00FF, 16'h0020, 16'h0000, 16'h00FF, 4'd5, 16'h00FF, 2};
    tab[6] = '{2'd0, 4'd5, 4'd5, 16'hBEEF, 16'h0020, 16'h0000, 16'h00FF, 4'd5, 16'h00FF, 3};
    // reset held two cycles
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 0);
      chk("rst_strobes", {reg_read | reg_write | reg_writeu, bus_out}, 0);
      chk("rst_done", {31'd0, done}, 0);
    end
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, req_ready}, 1);
    for (int i = 0; i < 7; i++) begin
      run_op(tab[i].op, tab[i].dst, tab[i].src, tab[i].imm, lat);
      apply_ref(tab[i].op, tab[i].dst, tab[i].src, tab[i].imm);
      chk($sformatf("vec%0d_lat", i), lat, tab[i].lat);
      chk($sformatf("vec%0d_wr", i), {16'd0, fw_wr}, {16'd0, tab[i].wr});
      chk($sformatf("vec%0d_wu", i), {16'd0, fw_wu}, {16'd0, tab[i].wu});
      chk($sformatf("vec%0d_bus", i), {16'd0, fw_bus}, {16'd0, tab[i].bus});
      chk($sformatf("vec%0d_reg", i), {16'd0, bank[tab[i].chk]}, {16'd0, tab[i].val});
      if (tab[i].op == 2'd3) begin
        chk("xchg_order", {rec_rd[0], rec_rd[1]}, {16'h0004, 16'h0002});
        chk("xchg_order_wr", {rec_wr[2], rec_wr[3]}, {16'h0002, 16'h0004});
        chk("xchg_r2", {16'd0, bank[2]}, 32'h1234);
      end
    end
    // back-to-back MOV with req_valid held high
    @(negedge clk);
    req_valid = 1; req_op = 2'd0; req_dst = 5; req_src = 5;
    n = 0; t0 = 0; t1 = 0;
    for (int c = 0; c < 30; c++) begin
      if (req_ready) begin
        if (n == 0) t0 = c; else t1 = c;
        n++;
        if (n == 2) break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1 req_valid = 0;
    for (int c = 0; c < 10 && !done; c++) @(negedge clk);
    chk("mov_accepts", n, 2);
    chk("mov_throughput", t1 - t0, 4);
    chk("mov_same_reg", {16'd0, bank[5]}, 32'h00FF);
    // reset during XCHG write phase
    run_op(2'd1, 4'd1, 4'd0, 16'h1234, lat); apply_ref(2'd1, 4'd1, 4'd0, 16'h1234);
    run_op(2'd1, 4'd2, 4'd0, 16'hABCD, lat); apply_ref(2'd1, 4'd2, 4'd0, 16'hABCD);
    @(negedge clk);
    req_valid = 1; req_op = 2'd3; req_dst = 1; req_src = 2;
    for (int c = 0; c < 20 && !req_ready; c++) @(negedge clk);
    @(posedge clk); #1 req_valid = 0;
    found = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (reg_write == 16'h0002) begin found = 1; break; end
    end
    chk("xchg_wra_seen", {31'd0, found}, 1);
    rst = 1; dc = done_cnt;
    @(negedge clk);
    chk("midrst_strobes", {reg_read | reg_write | reg_writeu, bus_out}, 0);
    chk("midrst_done_ready", {30'd0, done, req_ready}, 0);
    chk("midrst_r1", {16'd0, bank[1]}, 32'hABCD);
    chk("midrst_r2", {16'd0, bank[2]}, 32'hABCD);
    @(posedge clk); #1 rst = 0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", done_cnt - dc, 0);
    ref_m[1] = 16'hABCD;
    // randomized ops against the op-level reference
    for (int k = 0; k < 40; k++) begin
      op = 2'($urandom); d = 4'($urandom); s = 4'($urandom); imm = 16'($urandom);
      run_op(op, d, s, imm, lat);
      apply_ref(op, d, s, imm);
      chk($sformatf("rand%0d_lat", k), lat, lat_tab[op]);
      mism = 0;
      for (int i = 0; i < 16; i++) if (bank[i] !== ref_m[i]) mism++;
      chk($sformatf("rand%0d_bank", k), mism, 0);
    end
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
